// File: rtl/bsg_link_pkg.sv
// Shared link constants and types for the off-chip link receive path.
// A core word is BEATS beats of {ch1,ch0}, with beat 0 in the low bits.
package bsg_link_pkg;
  localparam int CH_WIDTH        = 8;
  localparam int CORE_WIDTH      = 64;
  localparam int BEATS           = CORE_WIDTH / (2 * CH_WIDTH);
  localparam int ELS_DEF         = 16;
  localparam int TOKEN_BATCH_DEF = 8;

  typedef logic [CORE_WIDTH-1:0]      core_word_t;
  typedef logic [$clog2(BEATS)-1:0]   beat_idx_t;
endpackage

// File: rtl/bsg_link_rx_fifo.sv
// Circular FIFO with registered count. An enqueue while full is accepted
// only when a dequeue frees a slot in the same cycle.
module bsg_link_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int ELS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_v_i,
  input  logic [WIDTH-1:0]         enq_data_i,
  input  logic                     deq_v_i,
  output logic [WIDTH-1:0]         deq_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(ELS+1)-1:0] count_o
);
  localparam int PTR_W = (ELS > 1) ? $clog2(ELS) : 1;
  localparam int CNT_W = $clog2(ELS+1);

  logic [WIDTH-1:0] mem_q [ELS];
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_ok, deq_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ELS-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == CNT_W'(ELS));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign deq_data_o = mem_q[rptr_q];

  always_comb begin
    deq_ok  = deq_v_i && !empty_o;
    enq_ok  = enq_v_i && (!full_o || deq_ok);
    rptr_d  = deq_ok ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = enq_ok ? ptr_inc(wptr_q) : wptr_q;
    count_d = count_q + CNT_W'(enq_ok) - CNT_W'(deq_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[wptr_q] <= enq_data_i;
  end
endmodule

// File: rtl/bsg_downstream_link_rx.sv
// Link receiver: assembles channel beats into core words, buffers them,
// and returns one token per TOKEN_BATCH words consumed by the core.
module bsg_downstream_link_rx
  import bsg_link_pkg::*;
#(
  parameter int ELS         = ELS_DEF,
  parameter int TOKEN_BATCH = TOKEN_BATCH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     io_valid_in,
  input  logic [CH_WIDTH-1:0]      io_data_in_ch0,
  input  logic [CH_WIDTH-1:0]      io_data_in_ch1,
  output logic [CORE_WIDTH-1:0]    core_data_out,
  output logic                     core_valid_out,
  input  logic                     core_yumi_in,
  output logic                     io_token_out,
  output logic [$clog2(ELS+1)-1:0] fifo_count,
  output logic                     overflow_o
);
  localparam int BEAT_W = 2 * CH_WIDTH;
  localparam int TOK_W  = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;

  beat_idx_t        beat_cnt_q, beat_cnt_d;
  core_word_t       word_q, word_d, assembled;
  logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
  logic             token_q, token_d, overflow_q, overflow_d;
  logic             word_done, deq, fifo_full, fifo_empty;

  always_comb begin
    assembled = word_q;
    assembled[beat_cnt_q*BEAT_W +: BEAT_W] = {io_data_in_ch1, io_data_in_ch0};
    word_done  = io_valid_in && (beat_cnt_q == beat_idx_t'(BEATS-1));
    word_d     = word_q;
    beat_cnt_d = beat_cnt_q;
    if (io_valid_in) begin
      word_d     = assembled;
      beat_cnt_d = word_done ? '0 : beat_cnt_q + 1'b1;
    end

    deq        = core_yumi_in && !fifo_empty;
    // A full FIFO still takes the word if the core frees a slot this cycle.
    overflow_d = overflow_q | (word_done && fifo_full && !deq);

    tok_cnt_d = tok_cnt_q;
    token_d   = 1'b0;
    if (deq) begin
      if (tok_cnt_q == TOK_W'(TOKEN_BATCH-1)) begin
        tok_cnt_d = '0;
        token_d   = 1'b1;
      end else begin
        tok_cnt_d = tok_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      word_q     <= '0;
      tok_cnt_q  <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      word_q     <= word_d;
      tok_cnt_q  <= tok_cnt_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  bsg_link_rx_fifo #(.WIDTH(CORE_WIDTH), .ELS(ELS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq_v_i   (word_done),
    .enq_data_i(assembled),
    .deq_v_i   (deq),
    .deq_data_o(core_data_out),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign core_valid_out = !fifo_empty;
  assign io_token_out   = token_q;
  assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_bsg_downstream_link_rx.sv
// Directed + random bench for bsg_downstream_link_rx against a queue-based
// model of beats, buffered words, overflow and token batches.
module tb_bsg_downstream_link_rx;
  localparam int ELS = 16;
  localparam int TB  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_valid_in = 1'b0;
  logic [7:0]  io_data_in_ch0 = '0, io_data_in_ch1 = '0;
  logic [63:0] core_data_out;
  logic        core_valid_out, core_yumi_in = 1'b0, io_token_out, overflow_o;
  logic [4:0]  fifo_count;

  bsg_downstream_link_rx #(.ELS(ELS), .TOKEN_BATCH(TB)) dut (
    .clk(clk), .rst(rst), .io_valid_in(io_valid_in),
    .io_data_in_ch0(io_data_in_ch0), .io_data_in_ch1(io_data_in_ch1),
    .core_data_out(core_data_out), .core_valid_out(core_valid_out),
    .core_yumi_in(core_yumi_in), .io_token_out(io_token_out),
    .fifo_count(fifo_count), .overflow_o(overflow_o));

  always #5 clk = ~clk;

  // Model state
  logic [63:0] m_q[$];
  logic [15:0] m_beats[$];
  logic        m_ovf, m_tok;
  int          m_deq_total;

  int checks = 0, passes = 0, pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_update();
    logic [63:0] w;
    if (rst) begin
      m_q.delete(); m_beats.delete();
      m_ovf = 1'b0; m_tok = 1'b0; m_deq_total = 0;
      return;
    end
    m_tok = 1'b0;
    if (core_yumi_in && m_q.size() != 0) begin
      void'(m_q.pop_front());
      m_deq_total++;
      m_tok = (m_deq_total % TB) == 0;
    end
    if (io_valid_in) begin
      m_beats.push_back({io_data_in_ch1, io_data_in_ch0});
      if (m_beats.size() == 4) begin
        w = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
        m_beats.delete();
        if (m_q.size() < ELS) m_q.push_back(w);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (io_token_out) pulses++;
    chk("valid", 64'(core_valid_out), 64'(m_q.size() != 0));
    chk("count", 64'(fifo_count), 64'(m_q.size()));
    chk("ovf",   64'(overflow_o), 64'(m_ovf));
    chk("token", 64'(io_token_out), 64'(m_tok));
    if (m_q.size() != 0) chk("head", core_data_out, m_q[0]);
  endtask

  task automatic beat(input logic [15:0] b);
    io_valid_in = 1'b1; {io_data_in_ch1, io_data_in_ch0} = b;
    step();
    io_valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int k = 0; k < 4; k++) beat(w[16*k +: 16]);
  endtask

  task automatic do_reset();
    rst = 1'b1; core_yumi_in = 1'b0; io_valid_in = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] w1, w;
    m_ovf = 1'b0; m_tok = 1'b0; m_deq_total = 0;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(core_valid_out), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);

    // Four consecutive beats
    beat(16'h2211); beat(16'h4433); beat(16'h6655);
    chk("pre_valid", 64'(core_valid_out), 64'd0);
    beat(16'h8877);
    chk("t1_valid", 64'(core_valid_out), 64'd1);
    chk("t1_data", core_data_out, 64'h8877665544332211);
    core_yumi_in = 1'b1; step(); core_yumi_in = 1'b0;

    // Gap of 3 idle cycles between beats 2 and 3
    beat(16'h2211); beat(16'h4433);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_count", 64'(fifo_count), 64'd0);
    end
    beat(16'h6655); beat(16'h8877);
    chk("t2_data", core_data_out, 64'h8877665544332211);

    // Overflow: 16 words fill, 17th dropped
    do_reset();
    w1 = {$urandom, $urandom};
    send_word(w1);
    for (int i = 1; i < ELS; i++) send_word({$urandom, $urandom});
    chk("full_count", 64'(fifo_count), 64'd16);
    send_word({$urandom, $urandom});
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk("ovf_count", 64'(fifo_count), 64'd16);
    chk("ovf_head", core_data_out, w1);
    step(); step();
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Full with same-cycle dequeue on the 17th word
    do_reset();
    for (int i = 0; i < ELS; i++) send_word({$urandom, $urandom});
    w = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) beat(w[16*k +: 16]);
    core_yumi_in = 1'b1; beat(w[63:48]); core_yumi_in = 1'b0;
    chk("fulldeq_count", 64'(fifo_count), 64'd16);
    chk("fulldeq_ovf", 64'(overflow_o), 64'd0);

    // Token batches
    do_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) send_word({$urandom, $urandom});
    core_yumi_in = 1'b1;
    for (int i = 0; i < 8; i++) step();
    core_yumi_in = 1'b0;
    chk("tok_last", 64'(io_token_out), 64'd1);
    step();
    chk("tok_one", 64'(pulses), 64'd1);
    for (int i = 0; i < 16; i++) send_word({$urandom, $urandom});
    core_yumi_in = 1'b1;
    for (int i = 0; i < 16; i++) step();
    core_yumi_in = 1'b0;
    step();
    chk("tok_three", 64'(pulses), 64'd3);

    // Reset mid-word with buffered words
    do_reset();
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom});
    beat(16'hAAAA); beat(16'hBBBB);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", 64'(core_valid_out), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_tok", 64'(io_token_out), 64'd0);
    send_word(64'h0123_4567_89AB_CDEF);
    chk("post_rst_data", core_data_out, 64'h0123_4567_89AB_CDEF);

    // Random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      io_valid_in    = ($urandom_range(0, 3) != 0);
      io_data_in_ch0 = 8'($urandom);
      io_data_in_ch1 = 8'($urandom);
      core_yumi_in   = ($urandom_range(0, 2) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; io_valid_in = 1'b0; core_yumi_in = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
